// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and helpers for the H-bridge PWM block
package pwm_pkg;

  localparam int CH_MAX = 8;
  localparam int DEAD_W = 4;

  // Bit positions of the two legs inside a channel's 2-bit output slice.
  localparam int LEG_A = 1;
  localparam int LEG_B = 0;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_hb_chan.sv
// rtl/pwm_hb_chan.sv - one H-bridge channel: shadow/active config, compare, leg output
// Optional dead-time on direction reversal: PWM_DEADTIME_EN.
module pwm_hb_chan
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              wr,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              wr_dir,
  input  logic              wr_on,
  input  logic [DUTY_W-1:0] cnt,
  output logic [1:0]        legs
);

  if (DEAD_CYC < 1 || DEAD_CYC > (2 ** DEAD_W) - 1) begin : g_bad_dead
    $error("pwm_hb_chan: DEAD_CYC out of range");
  end

  logic [DUTY_W-1:0] duty_sh, duty_act;
  logic              dir_sh, dir_act;
  logic              on_sh, on_act;
  logic              next_dir;
  logic              pwm;
  logic              gate;
  logic [1:0]        legs_next;

  // A write landing on the load cycle bypasses the shadow straight into active.
  assign next_dir = wr ? wr_dir : dir_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      dir_sh   <= 1'b0;
      on_sh    <= 1'b0;
      duty_act <= '0;
      dir_act  <= 1'b0;
      on_act   <= 1'b0;
    end else begin
      if (wr) begin
        duty_sh <= wr_duty;
        dir_sh  <= wr_dir;
        on_sh   <= wr_on;
      end
      if (load) begin
        duty_act <= wr ? wr_duty : duty_sh;
        dir_act  <= next_dir;
        on_act   <= wr ? wr_on : on_sh;
      end
    end
  end

  assign pwm = on_act && (cnt < duty_act);

  always_comb begin
    legs_next        = 2'b00;
    legs_next[LEG_A] = pwm && dir_act;
    legs_next[LEG_B] = pwm && !dir_act;
  end

`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead;

  // A reversal (including one during an active dead-time) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead <= '0;
    end else if (load && (next_dir != dir_act)) begin
      dead <= DEAD_W'(DEAD_CYC);
    end else if (dead != '0) begin
      dead <= dead - 1'b1;
    end
  end

  assign gate = (dead == '0);
`else
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      legs <= 2'b00;
    end else begin
      legs <= (en && gate) ? legs_next : 2'b00;
    end
  end

endmodule

// File: rtl/pwm_hbridge_ctrl.sv
// rtl/pwm_hbridge_ctrl.sv - multi-channel H-bridge PWM: prescaler, period counter, write decode
// Optional dead-time on direction reversal: PWM_DEADTIME_EN.
module pwm_hbridge_ctrl
  import pwm_pkg::*;
#(
  parameter int CH_NUM     = 2,
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 8,
  parameter int DEAD_CYC   = 4
) (
  input  logic                         i_sys_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [PRESCALE_W-1:0]        i_prescale,
  input  logic                         i_cfg_we,
  input  logic [clog2_min1(CH_NUM)-1:0] i_cfg_ch,
  input  logic [DUTY_W-1:0]            i_cfg_duty,
  input  logic                         i_cfg_dir,
  input  logic                         i_cfg_on,
  output logic [2*CH_NUM-1:0]          o_pwm_wave,
  output logic                         o_period_stb
);

  localparam int CH_W = clog2_min1(CH_NUM);

  if (CH_NUM < 1 || CH_NUM > CH_MAX) begin : g_bad_ch
    $error("pwm_hbridge_ctrl: CH_NUM out of range");
  end

  logic [PRESCALE_W-1:0] psc;
  logic [DUTY_W-1:0]     cnt;
  logic                  en_q;
  logic                  tick;
  logic                  boundary;
  logic                  load;

  // >= rather than == so a live shrink of i_prescale cannot strand the divider.
  assign tick     = i_en && (psc >= i_prescale);
  assign boundary = tick && (cnt == '1);
  assign load     = boundary || (i_en && !en_q);

  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      psc          <= '0;
      cnt          <= '0;
      en_q         <= 1'b0;
      o_period_stb <= 1'b0;
    end else begin
      en_q         <= i_en;
      o_period_stb <= boundary;
      if (!i_en) begin
        psc <= '0;
        cnt <= '0;
      end else if (tick) begin
        psc <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic wr;

    assign wr = i_cfg_we && (i_cfg_ch == CH_W'(c));

    pwm_hb_chan #(
      .DUTY_W   (DUTY_W),
      .DEAD_CYC (DEAD_CYC)
    ) u_chan (
      .clk     (i_sys_clk),
      .rst_n   (i_rst),
      .en      (i_en),
      .load    (load),
      .wr      (wr),
      .wr_duty (i_cfg_duty),
      .wr_dir  (i_cfg_dir),
      .wr_on   (i_cfg_on),
      .cnt     (cnt),
      .legs    (o_pwm_wave[2*c +: 2])
    );
  end

endmodule

// File: tb/tb_pwm_hbridge_ctrl.sv
// tb/tb_pwm_hbridge_ctrl.sv - self-checking bench for pwm_hbridge_ctrl (3 channels, per-period scoreboard)
module tb_pwm_hbridge_ctrl;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int DC = 4;
  localparam int WB = 2 * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] ps;
  logic          we;
  logic [1:0]    ch;
  logic [DW-1:0] duty;
  logic          dir;
  logic          on;
  logic [WB-1:0] wave;
  logic          stb;

  always #5 clk = ~clk;

  pwm_hbridge_ctrl #(
    .CH_NUM     (CH),
    .DUTY_W     (DW),
    .PRESCALE_W (PW),
    .DEAD_CYC   (DC)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_prescale   (ps),
    .i_cfg_we     (we),
    .i_cfg_ch     (ch),
    .i_cfg_duty   (duty),
    .i_cfg_dir    (dir),
    .i_cfg_on     (on),
    .o_pwm_wave   (wave),
    .o_period_stb (stb)
  );

  // One period window: high-sample count per output bit, first leg-B high of ch0,
  // strobe count/position and a both-legs-high flag.
  typedef struct packed {
    logic [WB-1:0][15:0] hi;
    logic [15:0]         first_b0;
    logic [7:0]          stb_cnt;
    logic                stb_last;
    logic                both;
  } win_t;

  win_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic win_t mk_exp(input int p, input int d0, input bit r0, input int d1, input bit r1);
    win_t e;
    int   m;
    m          = p + 1;
    e          = '0;
    e.hi[1]    = r0 ? 16'(d0 * m) : 16'd0;
    e.hi[0]    = r0 ? 16'd0 : 16'(d0 * m);
    e.hi[3]    = r1 ? 16'(d1 * m) : 16'd0;
    e.hi[2]    = r1 ? 16'd0 : 16'(d1 * m);
    e.first_b0 = (!r0 && d0 > 0) ? 16'd0 : 16'hFFFF;
    e.stb_cnt  = 8'd1;
    e.stb_last = 1'b1;
    e.both     = 1'b0;
    return e;
  endfunction

  task automatic write_cfg(input int c, input int d, input bit r, input bit o);
    ch   = 2'(c);
    duty = DW'(d);
    dir  = r;
    on   = o;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic sync_stb(output int nz);
    bit found;
    found = 1'b0;
    nz    = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (wave != '0) nz++;
      if (stb) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL sync_timeout act=no_strobe exp=strobe_within_5000");
    end
  endtask

  // Samples one full period starting right after a strobe sample; optionally
  // issues one config write after sample index wk.
  task automatic measure(input int p, input int wk, input int c, input int d, input bit r,
                         input bit o, output win_t w);
    int n;
    n          = 256 * (p + 1);
    w          = '0;
    w.first_b0 = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int b = 0; b < WB; b++) if (wave[b]) w.hi[b] = w.hi[b] + 16'd1;
      if (wave[0] && w.first_b0 == 16'hFFFF) w.first_b0 = 16'(i);
      for (int k = 0; k < CH; k++) if (wave[2*k] && wave[2*k+1]) w.both = 1'b1;
      if (stb) begin
        w.stb_cnt = w.stb_cnt + 8'd1;
        if (i == n - 1) w.stb_last = 1'b1;
      end
      if (i == wk) begin
        ch   = 2'(c);
        duty = DW'(d);
        dir  = r;
        on   = o;
        we   = 1'b1;
      end else if (i == wk + 1) begin
        we = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (wave !== '0) begin bad++; $display("FAIL reset_wave act=%b exp=%b", wave, 6'b0); end
    total++;
    if (stb !== 1'b0) begin bad++; $display("FAIL reset_stb act=%b exp=0", stb); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (wave !== '0) begin bad++; $display("FAIL reset_idle act=%b exp=%b", wave, 6'b0); end
  endtask

  task automatic test_basic();
    win_t w, e;
    int   nz;
    write_cfg(0, 64, 1'b1, 1'b1);
    write_cfg(2, 100, 1'b1, 1'b0);
    sync_stb(nz);
    exp_q.push_back(mk_exp(0, 64, 1, 0, 1));
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL basic_period act=%h exp=%h", w, e); end
  endtask

  task automatic test_mid_period_write();
    win_t w, e;
    exp_q.push_back(mk_exp(0, 64, 1, 0, 1));
    measure(0, 5, 1, 32, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL mid_setup act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 64, 1, 32, 1));
    measure(0, 100, 1, 200, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL mid_keep_old act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 64, 1, 200, 1));
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL mid_take_new act=%h exp=%h", w, e); end
  endtask

  task automatic test_write_through();
    win_t w, e;
    exp_q.push_back(mk_exp(0, 64, 1, 200, 1));
    measure(0, 254, 1, 100, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL wt_boundary act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 64, 1, 100, 1));
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL wt_next act=%h exp=%h", w, e); end
  endtask

  task automatic test_duty_limits();
    win_t w, e;
    exp_q.push_back(mk_exp(0, 64, 1, 100, 1));
    measure(0, 5, 0, 0, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL lim_pre act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 0, 1, 100, 1));
    measure(0, 5, 0, 255, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL lim_duty0 act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 255, 1, 100, 1));
    measure(0, 5, 0, 64, 1'b0, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL lim_duty255 act=%h exp=%h", w, e); end
  endtask

  task automatic test_reversal();
    win_t w, e;
    e = mk_exp(0, 64, 0, 100, 1);
`ifdef PWM_DEADTIME_EN
    e.hi[0]    = 16'(64 - DC);
    e.first_b0 = 16'(DC);
`endif
    exp_q.push_back(e);
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL reversal act=%h exp=%h", w, e); end
  endtask

  task automatic test_prescale_enable();
    win_t w, e;
    int   pos;
    ps = 8'd3;
    exp_q.push_back(mk_exp(3, 64, 0, 100, 1));
    measure(3, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL ps3_period act=%h exp=%h", w, e); end
    repeat (20) @(negedge clk);
    total++;
    if (wave !== 6'b001001) begin bad++; $display("FAIL en_pre act=%b exp=%b", wave, 6'b001001); end
    en = 1'b0;
    @(negedge clk);
    total++;
    if (wave !== '0) begin bad++; $display("FAIL en_drop act=%b exp=%b", wave, 6'b0); end
    write_cfg(1, 16, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    en  = 1'b1;
    pos = -1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (wave !== 6'b001001) begin bad++; $display("FAIL reen_first act=%b exp=%b", wave, 6'b001001); end
      end
      if (i == 64) begin
        total++;
        if (wave !== 6'b000001) begin bad++; $display("FAIL reen_shadow act=%b exp=%b", wave, 6'b000001); end
      end
      if (stb && pos < 0) pos = i;
    end
    total++;
    if (pos != 1023) begin bad++; $display("FAIL reen_cnt0 act=%0d exp=1023", pos); end
    ps = 8'd0;
    exp_q.push_back(mk_exp(0, 64, 0, 16, 1));
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL ps0_back act=%h exp=%h", w, e); end
  endtask

  task automatic test_async_reset();
    win_t w, e;
    int   nz;
    repeat (10) @(negedge clk);
    total++;
    if (wave !== 6'b001001) begin bad++; $display("FAIL rst_pre act=%b exp=%b", wave, 6'b001001); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (wave !== '0) begin bad++; $display("FAIL rst_async act=%b exp=%b", wave, 6'b0); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sync_stb(nz);
    total++;
    if (nz != 0) begin bad++; $display("FAIL rst_quiet act=%0d exp=0", nz); end
    exp_q.push_back(mk_exp(0, 0, 1, 0, 1));
    measure(0, 5, 3, 100, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL rst_idle act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 0, 1, 0, 1));
    measure(0, 5, 0, 50, 1'b1, 1'b1, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL bad_ch_ignored act=%h exp=%h", w, e); end
    exp_q.push_back(mk_exp(0, 50, 1, 0, 1));
    measure(0, -1, 0, 0, 0, 0, w);
    e = exp_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL rst_reconfig act=%h exp=%h", w, e); end
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b1;
    ps   = '0;
    we   = 1'b0;
    ch   = '0;
    duty = '0;
    dir  = 1'b0;
    on   = 1'b0;
    test_reset();
    test_basic();
    test_mid_period_write();
    test_write_through();
    test_duty_limits();
    test_reversal();
    test_prescale_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
